// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline stall/flush sequencer and the pipeline it controls.
// The controller takes the master modport; the pipeline/datapath side takes the slave modport.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard and memory-status inputs to the controller
  logic             idex_mem_read;
  logic [4:0]       idex_reg_dest;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ex_branch_taken;
  logic             ex_jump;
  logic             exmem_mem_read;
  logic             exmem_mem_write;
  logic             dmem_ready;

  // enables, squash strobes and status from the controller
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             dmem_req;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cycles;

  // Handshake: dmem_req is the valid, dmem_ready the ready; an access completes
  // in the cycle both are 1, and the request is held (pipeline frozen) until then.
  modport master (
    input  idex_mem_read, idex_reg_dest, ifid_rs, ifid_rt,
    input  ex_branch_taken, ex_jump, exmem_mem_read, exmem_mem_write, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, dmem_req, mem_error, stall_cycles
  );

  modport slave (
    output idex_mem_read, idex_reg_dest, ifid_rs, ifid_rt,
    output ex_branch_taken, ex_jump, exmem_mem_read, exmem_mem_write, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, dmem_req, mem_error, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for a five-stage MIPS pipeline: owns every pipeline register enable
// and resolves load-use hazards, taken branches/jumps and variable-latency data memory.
module pipeline_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic           clock,
  input  logic           resetn,
  pipeline_ctrl_if.master bus,
  output logic           debug_state
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state;
  state_t           state_next;
  logic [7:0]       wcnt;
  logic [7:0]       wcnt_next;
  logic             set_error;
  logic             freeze;
  logic             mem_error_q;
  logic [CNT_W-1:0] stall_q;

  logic mem_acc;
  logic lu_haz;
  logic redirect;

  // raw (pre-reset-gating) versions of the combinational outputs
  logic pc_en_c;
  logic ifid_en_c;
  logic idex_en_c;
  logic exmem_en_c;
  logic memwb_en_c;
  logic ifid_flush_c;
  logic idex_flush_c;
  logic dmem_req_c;

  assign mem_acc  = bus.exmem_mem_read | bus.exmem_mem_write;
  assign redirect = bus.ex_branch_taken | bus.ex_jump;
  assign lu_haz   = bus.idex_mem_read && (bus.idex_reg_dest != 5'd0) &&
                    ((bus.idex_reg_dest == bus.ifid_rs) || (bus.idex_reg_dest == bus.ifid_rt));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      wcnt  <= 8'd0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // Next state, wait counter and whether this cycle freezes the whole pipeline.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    set_error  = 1'b0;
    freeze     = 1'b0;
    case (state)
      RUN: begin
        if (mem_acc && !bus.dmem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          wcnt_next  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) begin
          state_next = RUN;
          wcnt_next  = 8'd0;
        end else if (wcnt < WAIT_LIM) begin
          freeze    = 1'b1;
          wcnt_next = wcnt + 8'd1;
        end else begin
          // timeout: abandon the access and release as if it had completed
          set_error  = 1'b1;
          state_next = RUN;
          wcnt_next  = 8'd0;
        end
      end
      default: begin
        state_next = RUN;
        wcnt_next  = 8'd0;
      end
    endcase
  end

  // Enables and squash strobes; on a release cycle the frozen EX/ID inputs are re-evaluated.
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    exmem_en_c   = 1'b1;
    memwb_en_c   = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    dmem_req_c   = (state == MEM_WAIT) || mem_acc;
    if (freeze) begin
      pc_en_c    = 1'b0;
      ifid_en_c  = 1'b0;
      idex_en_c  = 1'b0;
      exmem_en_c = 1'b0;
      memwb_en_c = 1'b0;
    end else if (redirect) begin
      // the load-use victim is itself on the wrong path, so only squash
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
    end else if (lu_haz) begin
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      idex_flush_c = 1'b1;
    end
  end

  always_comb begin
    bus.pc_en      = resetn & pc_en_c;
    bus.ifid_en    = resetn & ifid_en_c;
    bus.idex_en    = resetn & idex_en_c;
    bus.exmem_en   = resetn & exmem_en_c;
    bus.memwb_en   = resetn & memwb_en_c;
    bus.ifid_flush = resetn & ifid_flush_c;
    bus.idex_flush = resetn & idex_flush_c;
    bus.dmem_req   = resetn & dmem_req_c;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_error_q <= 1'b0;
    end else if (set_error) begin
      mem_error_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.mem_error    = mem_error_q;
  assign bus.stall_cycles = stall_q;
  assign debug_state      = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard, redirect, memory wait, timeout, reset and saturation cases.
module tb_pipeline_ctrl;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;

  logic clock;
  logic resetn;
  logic debug_state;
  int   total;
  int   bad;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus),
    .debug_state (debug_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected: en = {pc,ifid,idex,exmem,memwb}, fl = {ifid_flush,idex_flush}
  task automatic chk_out(input string tag, input logic [4:0] en, input logic [1:0] fl,
                         input logic req);
    logic [7:0] obs;
    obs = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_flush, bus.dmem_req};
    chk(tag, 32'(obs), 32'({en, fl, req}));
  endtask

  task automatic clear_inputs();
    bus.idex_mem_read   = 1'b0;
    bus.idex_reg_dest   = 5'd0;
    bus.ifid_rs         = 5'd0;
    bus.ifid_rt         = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_jump         = 1'b0;
    bus.exmem_mem_read  = 1'b0;
    bus.exmem_mem_write = 1'b0;
    bus.dmem_ready      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_inputs();
    resetn = 1'b0;
    bus.exmem_mem_read = 1'b1;
    bus.ex_jump        = 1'b1;

    // reset: every output forced low even with active inputs
    settle();
    chk_out("reset_outputs", 5'b00000, 2'b00, 1'b0);
    chk("reset_stall", 32'(bus.stall_cycles), 32'd0);
    chk("reset_err", 32'(bus.mem_error), 32'd0);
    chk("reset_state", 32'(debug_state), 32'd0);
    next_cycle();
    clear_inputs();
    resetn = 1'b1;

    settle();
    chk_out("idle_run", 5'b11111, 2'b00, 1'b0);

    // load-use on rs
    next_cycle();
    bus.idex_mem_read = 1'b1; bus.idex_reg_dest = 5'd5; bus.ifid_rs = 5'd5;
    settle();
    chk_out("lu_rs", 5'b00111, 2'b01, 1'b0);
    next_cycle();
    bus.idex_mem_read = 1'b0;
    settle();
    chk_out("lu_after", 5'b11111, 2'b00, 1'b0);
    chk("lu_stall_cnt", 32'(bus.stall_cycles), 32'd1);

    // load-use on rt
    next_cycle();
    clear_inputs();
    bus.idex_mem_read = 1'b1; bus.idex_reg_dest = 5'd7; bus.ifid_rt = 5'd7; bus.ifid_rs = 5'd3;
    settle();
    chk_out("lu_rt", 5'b00111, 2'b01, 1'b0);

    // $zero destination never stalls
    next_cycle();
    clear_inputs();
    bus.idex_mem_read = 1'b1;
    settle();
    chk_out("zero_dep", 5'b11111, 2'b00, 1'b0);
    chk("zero_stall_cnt", 32'(bus.stall_cycles), 32'd2);

    // branch together with a load-use: redirect wins
    next_cycle();
    bus.ex_branch_taken = 1'b1; bus.idex_reg_dest = 5'd5; bus.ifid_rs = 5'd5;
    settle();
    chk_out("branch_lu", 5'b11111, 2'b11, 1'b0);
    next_cycle();
    clear_inputs();
    settle();
    chk("branch_stall_cnt", 32'(bus.stall_cycles), 32'd2);

    // dmem_ready without an access is ignored; zero-wait access does not stall
    next_cycle();
    bus.dmem_ready = 1'b1;
    settle();
    chk_out("ready_no_acc", 5'b11111, 2'b00, 1'b0);
    next_cycle();
    bus.exmem_mem_read = 1'b1;
    settle();
    chk_out("zero_wait", 5'b11111, 2'b00, 1'b1);
    next_cycle();
    clear_inputs();
    settle();
    chk("zero_wait_state", 32'(debug_state), 32'd0);
    chk("zero_wait_cnt", 32'(bus.stall_cycles), 32'd2);

    // memory wait: ready low 3 cycles, jump held throughout
    reset_pulse();
    bus.exmem_mem_read = 1'b1; bus.ex_jump = 1'b1;
    settle();
    chk("mw_cnt_cleared", 32'(bus.stall_cycles), 32'd0);
    chk_out("mw_c1", 5'b00000, 2'b00, 1'b1);
    next_cycle();
    settle();
    chk_out("mw_c2", 5'b00000, 2'b00, 1'b1);
    chk("mw_c2_state", 32'(debug_state), 32'd1);
    next_cycle();
    settle();
    chk_out("mw_c3", 5'b00000, 2'b00, 1'b1);
    next_cycle();
    bus.dmem_ready = 1'b1;
    settle();
    chk_out("mw_release", 5'b11111, 2'b11, 1'b1);
    chk("mw_stall_cnt", 32'(bus.stall_cycles), 32'd3);
    next_cycle();
    clear_inputs();
    settle();
    chk_out("mw_after", 5'b11111, 2'b00, 1'b0);
    chk("mw_after_state", 32'(debug_state), 32'd0);
    chk("mw_err_clear", 32'(bus.mem_error), 32'd0);

    // timeout with WAIT_MAX=4: four frozen cycles, then release and sticky error
    reset_pulse();
    bus.exmem_mem_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_out($sformatf("to_frozen%0d", i), 5'b00000, 2'b00, 1'b1);
      next_cycle();
    end
    settle();
    chk_out("to_release", 5'b11111, 2'b00, 1'b1);
    chk("to_err_not_yet", 32'(bus.mem_error), 32'd0);
    next_cycle();
    clear_inputs();
    settle();
    chk_out("to_run", 5'b11111, 2'b00, 1'b0);
    chk("to_err_set", 32'(bus.mem_error), 32'd1);
    chk("to_state", 32'(debug_state), 32'd0);
    chk("to_stall_cnt", 32'(bus.stall_cycles), 32'd4);
    next_cycle();
    next_cycle();
    settle();
    chk("to_err_sticky", 32'(bus.mem_error), 32'd1);

    // reset dropped during the 2nd MEM_WAIT cycle
    next_cycle();
    bus.exmem_mem_read = 1'b1;
    next_cycle();
    next_cycle();
    settle();
    chk("rmw_state", 32'(debug_state), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk_out("rmw_outputs", 5'b00000, 2'b00, 1'b0);
    chk("rmw_err", 32'(bus.mem_error), 32'd0);
    chk("rmw_stall", 32'(bus.stall_cycles), 32'd0);
    chk("rmw_state_reset", 32'(debug_state), 32'd0);
    next_cycle();
    clear_inputs();
    resetn = 1'b1;
    settle();
    chk_out("rmw_run", 5'b11111, 2'b00, 1'b0);
    chk("rmw_err_after", 32'(bus.mem_error), 32'd0);
    chk("rmw_stall_after", 32'(bus.stall_cycles), 32'd0);

    // held hazard saturates the 4-bit stall counter at 15
    next_cycle();
    bus.idex_mem_read = 1'b1; bus.idex_reg_dest = 5'd9; bus.ifid_rt = 5'd9;
    for (int i = 0; i < 14; i++) next_cycle();
    settle();
    chk("sat_14", 32'(bus.stall_cycles), 32'd14);
    for (int i = 0; i < 6; i++) next_cycle();
    settle();
    chk("sat_hold", 32'(bus.stall_cycles), 32'd15);
    next_cycle();
    clear_inputs();
    settle();
    chk_out("sat_release", 5'b11111, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
